bus_bridge_hs: RTL and testbench

//  Parametrised CPU-to-peripheral bridge with handshake: replaces the fixed 3-target combinational decoder.

---
 rtl/bus_bridge_hs_if.sv | 34 +++
 rtl/bus_bridge_hs.sv | 188 ++++++++++++++++++
 tb/tb_bus_bridge_hs.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/bus_bridge_hs_if.sv
// rtl/bus_bridge_hs_if.sv - CPU/device signal bundle for the handshake bridge
interface bus_bridge_hs_if #(
  parameter int NDEV = 3
);
  logic                 PrReq;
  logic                 PrWE;
  logic [31:0]          PrAddr;
  logic [31:0]          PrWD;
  logic [3:0]           PrByteEn;
  logic [31:0]          PrRD;
  logic                 PrReady;
  logic                 PrErr;
  logic [NDEV-1:0]      DevSel;
  logic                 DevWE;
  logic [31:0]          DevAddr;
  logic [31:0]          DevWD;
  logic [3:0]           DevByteEn;
  logic [NDEV*32-1:0]   DevRD;
  logic [NDEV-1:0]      DevAck;
  logic [NDEV-1:0]      DevIrq;
  logic [5:0]           HWInt;

  // Bridge side: takes CPU requests and device responses, drives the rest.
  modport slave (
    input  PrReq, PrWE, PrAddr, PrWD, PrByteEn, DevRD, DevAck, DevIrq,
    output PrRD, PrReady, PrErr, DevSel, DevWE, DevAddr, DevWD, DevByteEn, HWInt
  );

  // Environment side: the CPU and the devices together.
  modport master (
    output PrReq, PrWE, PrAddr, PrWD, PrByteEn, DevRD, DevAck, DevIrq,
    input  PrRD, PrReady, PrErr, DevSel, DevWE, DevAddr, DevWD, DevByteEn, HWInt
  );
endinterface

// File: rtl/bus_bridge_hs.sv
// rtl/bus_bridge_hs.sv - base/mask decoding CPU-to-peripheral bridge with req/ack, timeout and irq collection
module bus_bridge_hs #(
  parameter int                 NDEV     = 3,
  parameter logic [NDEV*32-1:0] BASE     = {NDEV{32'h0}},
  parameter logic [NDEV*32-1:0] MASK     = {NDEV{32'hFFFF0000}},
  parameter int                 TIMEOUT  = 15,
  parameter logic [NDEV-1:0]    IRQ_EDGE = {NDEV{1'b0}}
) (
  input  logic           clk,
  input  logic           reset,
  bus_bridge_hs_if.slave bus
);

  typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_RESP} state_t;

  state_t          state_q, state_d;
  logic [7:0]      cnt_q, cnt_d;
  logic [NDEV-1:0] sel_q, sel_d;
  logic            we_q, we_d;
  logic [31:0]     addr_q, addr_d;
  logic [31:0]     wd_q, wd_d;
  logic [3:0]      be_q, be_d;
  logic [31:0]     rd_q, rd_d;
  logic            ready_q, ready_d;
  logic            err_q, err_d;
  logic            berr_q, berr_d;
  logic [NDEV-1:0] irq_q;
  logic [NDEV-1:0] pend_q, pend_d;
  logic [NDEV-1:0] pend_clr;

  logic            hit_found;
  logic [NDEV-1:0] hit_onehot;
  logic [31:0]     hit_offset;
  logic            sel_ack;
  logic [31:0]     sel_rd;
  logic [NDEV-1:0] dev_int;

  // Address decode: the lowest-indexed matching window wins.
  always_comb begin
    hit_found  = 1'b0;
    hit_onehot = '0;
    hit_offset = '0;
    for (int i = 0; i < NDEV; i++) begin
      if (!hit_found && ((bus.PrAddr & MASK[32*i +: 32]) == BASE[32*i +: 32])) begin
        hit_found     = 1'b1;
        hit_onehot[i] = 1'b1;
        hit_offset    = bus.PrAddr & ~MASK[32*i +: 32];
      end
    end
  end

  // Pick ack and read data of the selected target only; others are ignored.
  always_comb begin
    sel_ack = 1'b0;
    sel_rd  = '0;
    for (int i = 0; i < NDEV; i++) begin
      if (sel_q[i]) begin
        sel_ack = bus.DevAck[i];
        sel_rd  = bus.DevRD[32*i +: 32];
      end
    end
  end

  // Transaction FSM: next state and every registered output.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sel_d    = sel_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wd_d     = wd_q;
    be_d     = be_q;
    rd_d     = rd_q;
    ready_d  = 1'b0;
    err_d    = err_q;
    berr_d   = berr_q;
    pend_clr = '0;
    unique case (state_q)
      ST_IDLE: begin
        err_d = 1'b0;
        rd_d  = '0;
        if (bus.PrReq) begin
          if (hit_found) begin
            sel_d   = hit_onehot;
            we_d    = bus.PrWE;
            addr_d  = hit_offset;
            wd_d    = bus.PrWD;
            be_d    = bus.PrByteEn;
            cnt_d   = '0;
            state_d = ST_BUSY;
          end else begin
            // A miss never reaches any device: straight to an error completion.
            err_d   = 1'b1;
            ready_d = 1'b1;
            berr_d  = 1'b1;
            state_d = ST_RESP;
          end
        end
      end
      ST_BUSY: begin
        if (sel_ack) begin
          rd_d     = we_q ? 32'h0 : sel_rd;
          err_d    = 1'b0;
          ready_d  = 1'b1;
          berr_d   = 1'b0;
          sel_d    = '0;
          we_d     = 1'b0;
          pend_clr = sel_q;
          state_d  = ST_RESP;
        end else if (cnt_q == 8'(TIMEOUT - 1)) begin
          rd_d     = '0;
          err_d    = 1'b1;
          ready_d  = 1'b1;
          berr_d   = 1'b1;
          sel_d    = '0;
          we_d     = 1'b0;
          state_d  = ST_RESP;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_RESP: begin
        err_d   = 1'b0;
        rd_d    = '0;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Edge-mode pending bits: a fresh rising edge beats a same-cycle clear.
  always_comb begin
    pend_d = (pend_q & ~pend_clr) | (bus.DevIrq & ~irq_q & IRQ_EDGE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      sel_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wd_q    <= '0;
      be_q    <= '0;
      rd_q    <= '0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      berr_q  <= 1'b0;
      irq_q   <= '0;
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wd_q    <= wd_d;
      be_q    <= be_d;
      rd_q    <= rd_d;
      ready_q <= ready_d;
      err_q   <= err_d;
      berr_q  <= berr_d;
      irq_q   <= bus.DevIrq;
      pend_q  <= pend_d;
    end
  end

  // Interrupt vector: level targets use the registered input, edge targets the pending bit.
  always_comb begin
    dev_int            = (IRQ_EDGE & pend_q) | (~IRQ_EDGE & irq_q);
    bus.HWInt          = '0;
    bus.HWInt[NDEV-1:0] = dev_int;
    bus.HWInt[5]       = berr_q;
  end

  assign bus.PrRD      = rd_q;
  assign bus.PrReady   = ready_q;
  assign bus.PrErr     = err_q;
  assign bus.DevSel    = sel_q;
  assign bus.DevWE     = we_q;
  assign bus.DevAddr   = addr_q;
  assign bus.DevWD     = wd_q;
  assign bus.DevByteEn = be_q;

endmodule

// File: tb/tb_bus_bridge_hs.sv
// tb/tb_bus_bridge_hs.sv - randomized self-checking bench for bus_bridge_hs
module tb_bus_bridge_hs;

  localparam int          NDEV    = 3;
  localparam int          TIMEOUT = 15;
  localparam logic [2:0]  IRQ_E   = 3'b010;
  localparam logic [31:0] MSK     = 32'hFFFF0000;

  logic clk;
  logic rst_n;

  int n_total = 0;
  int n_pass  = 0;

  logic [31:0] bases [3];

  logic       irq_rand_en = 1'b0;
  logic       chk_en      = 1'b0;
  logic [2:0] m_prev, m_pend, clr_nx;
  logic       m_berr, berr_set_nx, berr_clr_nx;

  bus_bridge_hs_if #(.NDEV(NDEV)) bus ();

  bus_bridge_hs #(
    .NDEV     (NDEV),
    .BASE     ({32'h7F100000, 32'h7F000000, 32'h00000000}),
    .MASK     ({3{MSK}}),
    .TIMEOUT  (TIMEOUT),
    .IRQ_EDGE (IRQ_E)
  ) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) $display("FAIL %s: got %h expected %h", tag, obs, exp);
    else n_pass++;
  endtask

  function automatic int ref_target(input logic [31:0] a);
    for (int i = 0; i < 3; i++) if ((a & MSK) == bases[i]) return i;
    return -1;
  endfunction

  // Interrupt/bus-error reference: what HWInt must show after each edge.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_prev = '0;
      m_pend = '0;
      m_berr = 1'b0;
    end else begin
      m_pend = (m_pend & ~clr_nx) | (bus.DevIrq & ~m_prev & IRQ_E);
      m_prev = bus.DevIrq;
      if (berr_set_nx) m_berr = 1'b1;
      else if (berr_clr_nx) m_berr = 1'b0;
    end
  end

  always @(posedge clk) begin
    #3;
    if (chk_en)
      check("hwint", 32'(bus.HWInt),
            32'({m_berr, 2'b00, (IRQ_E & m_pend) | (~IRQ_E & m_prev)}));
  end

  task automatic step();
    @(negedge clk);
    if (irq_rand_en && $urandom_range(0, 3) == 0) bus.DevIrq = bus.DevIrq ^ 3'($urandom);
  endtask

  task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [3:0] be, input int delay, input logic [31:0] rdata);
    int t, exp_busy, cyc, busy_seen;
    logic exp_err, seen_ready, hold_bad;
    logic [2:0] sel_or, exp_sel;
    logic [31:0] obs_rd, exp_rd;
    logic obs_err;
    t = ref_target(addr);
    if (t < 0) begin exp_busy = 0; exp_err = 1'b1; end
    else if (delay >= TIMEOUT) begin exp_busy = TIMEOUT; exp_err = 1'b1; end
    else begin exp_busy = delay + 1; exp_err = 1'b0; end
    exp_sel = (t >= 0) ? 3'(1 << t) : 3'b000;
    exp_rd  = (exp_err || we) ? 32'h0 : rdata;
    step();
    bus.DevRD = {$urandom, $urandom, $urandom};
    if (t >= 0) bus.DevRD[32*t +: 32] = rdata;
    bus.PrReq = 1'b1; bus.PrWE = we; bus.PrAddr = addr; bus.PrWD = wd; bus.PrByteEn = be;
    if (t < 0) berr_set_nx = 1'b1;
    @(posedge clk);
    cyc = 0; busy_seen = 0; seen_ready = 1'b0; hold_bad = 1'b0; sel_or = '0;
    obs_rd = '0; obs_err = 1'b0;
    while (!seen_ready && cyc < 40) begin
      step();
      cyc++;
      bus.PrReq = 1'b0; bus.DevAck = '0;
      berr_set_nx = 1'b0; berr_clr_nx = 1'b0; clr_nx = '0;
      if (bus.PrReady) begin
        seen_ready = 1'b1;
        obs_rd = bus.PrRD;
        obs_err = bus.PrErr;
      end else begin
        sel_or |= bus.DevSel;
        if (bus.DevSel != 0) begin
          busy_seen++;
          if (bus.DevSel != exp_sel || bus.DevWE != we || bus.DevAddr != (addr & ~MSK) ||
              bus.DevWD != wd || bus.DevByteEn != be) hold_bad = 1'b1;
        end
        if (t >= 0 && cyc <= exp_busy) begin
          bus.DevAck = 3'($urandom) & ~exp_sel;
          if (cyc == exp_busy) begin
            if (!exp_err) begin
              bus.DevAck[t] = 1'b1;
              clr_nx[t] = 1'b1;
              berr_clr_nx = 1'b1;
            end else begin
              berr_set_nx = 1'b1;
            end
          end
        end
      end
    end
    check("ready_seen", 32'(seen_ready), 32'd1);
    check("latency", 32'(cyc), 32'(exp_busy + 1));
    check("pr_err", 32'(obs_err), 32'(exp_err));
    check("pr_rd", obs_rd, exp_rd);
    if (t >= 0) begin
      check("busy_cycles", 32'(busy_seen), 32'(exp_busy));
      check("dev_hold", 32'(hold_bad), 32'd0);
    end else begin
      check("miss_nosel", 32'(sel_or), 32'd0);
    end
    step();
    bus.DevAck = '0;
    check("ready_pulse", 32'(bus.PrReady), 32'd0);
    check("sel_drop", 32'(bus.DevSel), 32'd0);
    check("we_drop", 32'(bus.DevWE), 32'd0);
  endtask

  task automatic random_access();
    int r;
    logic [31:0] a;
    r = $urandom_range(0, 3);
    if (r < 3) a = bases[r] | 32'($urandom_range(0, 16'hFFFF));
    else begin
      a = $urandom;
      while (ref_target(a) >= 0) a = $urandom;
    end
    access(1'($urandom), a, $urandom, 4'($urandom), $urandom_range(0, 19), $urandom);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic bad;
    bases[0] = 32'h00000000;
    bases[1] = 32'h7F000000;
    bases[2] = 32'h7F100000;
    clr_nx = '0; berr_set_nx = 1'b0; berr_clr_nx = 1'b0;
    rst_n = 1'b0;
    bus.PrReq = 1'b0; bus.PrWE = 1'b0; bus.PrAddr = '0; bus.PrWD = '0; bus.PrByteEn = '0;
    bus.DevRD = '0; bus.DevAck = '0; bus.DevIrq = '0;
    repeat (3) step();
    check("rst_prrd", bus.PrRD, 32'h0);
    check("rst_ready", 32'(bus.PrReady), 32'd0);
    check("rst_err", 32'(bus.PrErr), 32'd0);
    check("rst_sel", 32'(bus.DevSel), 32'd0);
    check("rst_we", 32'(bus.DevWE), 32'd0);
    check("rst_addr", bus.DevAddr, 32'h0);
    check("rst_wd", bus.DevWD, 32'h0);
    check("rst_be", 32'(bus.DevByteEn), 32'd0);
    check("rst_hwint", 32'(bus.HWInt), 32'd0);
    rst_n = 1'b1;
    chk_en = 1'b1;
    step();

    access(1'b0, 32'h00000010, 32'h0, 4'hF, 0, 32'h12345678);
    access(1'b1, 32'h7F000004, 32'h0000CAFE, 4'h3, 4, 32'hDEADBEEF);
    access(1'b0, 32'h50000000, 32'h0, 4'hF, 0, 32'h0);
    check("berr_set", 32'(bus.HWInt[5]), 32'd1);
    access(1'b0, 32'h00000020, 32'h0, 4'hF, 2, 32'hA5A55A5A);
    check("berr_clr", 32'(bus.HWInt[5]), 32'd0);
    access(1'b0, 32'h7F100040, 32'h0, 4'hF, 100, 32'h11111111);
    check("berr_timeout", 32'(bus.HWInt[5]), 32'd1);

    step(); bus.DevIrq[1] = 1'b1;
    step(); bus.DevIrq[1] = 1'b0;
    bus.DevIrq[0] = 1'b1;
    step(); bus.DevIrq[0] = 1'b0;
    repeat (3) step();
    check("edge_hold", 32'(bus.HWInt[1]), 32'd1);
    check("level_follow", 32'(bus.HWInt[0]), 32'd0);
    access(1'b0, 32'h7F000100, 32'h0, 4'hF, 1, 32'h0BADF00D);
    check("edge_clr", 32'(bus.HWInt[1]), 32'd0);

    step();
    bus.PrReq = 1'b1; bus.PrWE = 1'b1; bus.PrAddr = 32'h7F100020; bus.PrWD = 32'h55; bus.PrByteEn = 4'hF;
    step();
    bus.PrReq = 1'b0;
    step();
    rst_n = 1'b0;
    #1;
    check("mid_rst_sel", 32'(bus.DevSel), 32'd0);
    check("mid_rst_we", 32'(bus.DevWE), 32'd0);
    check("mid_rst_addr", bus.DevAddr, 32'h0);
    step(); bus.DevAck = 3'b100;
    step(); rst_n = 1'b1;
    bad = 1'b0;
    repeat (3) begin
      step();
      if (bus.PrReady || bus.DevSel != 0 || bus.PrErr) bad = 1'b1;
    end
    bus.DevAck = '0;
    check("late_ack_ignored", 32'(bad), 32'd0);
    access(1'b0, 32'h7F100008, 32'h0, 4'hF, 3, 32'hFEEDFACE);

    irq_rand_en = 1'b1;
    for (int k = 0; k < 60; k++) random_access();
    irq_rand_en = 1'b0;
    repeat (3) step();
    chk_en = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
